// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and load/store share one synchronous RAM port.
// Reads take two cycles (address, then registered data); stores complete in the accept cycle.
//
//   state | meaning
//   IDLE  | free: arbitrate, accept a read or perform a store
//   IF_RD | fetch address presented last edge, capture ram_dout at end of cycle
//   LS_RD | load address presented last edge, capture extracted ram_dout at end of cycle
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_rsp_valid,
  output logic [31:0]           if_rsp_data,
  input  logic                  if_flush,

  input  logic                  ls_valid,
  output logic                  ls_ready,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic                  ls_we,
  input  logic [1:0]            ls_size,
  input  logic                  ls_signed,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_rsp_valid,
  output logic [31:0]           ls_rsp_data,

  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [3:0]            ram_wmask,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    LS_RD = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    last_ls;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]              size_q;
  logic                    signed_q;
  logic                    if_rsp_q;
  logic                    grant_if;
  logic                    grant_ls;
  logic                    store_acc;
  logic [31:0]             load_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ready is only offered in IDLE and never while reset is asserted.
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_ls  = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n) begin
          grant_if = if_valid && (!ls_valid || last_ls);
          grant_ls = ls_valid && !grant_if;
          if (grant_if) begin
            state_nxt = IF_RD;
          end else if (grant_ls && !ls_we) begin
            state_nxt = LS_RD;
          end
        end
      end
      IF_RD:   state_nxt = IDLE;
      LS_RD:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign if_ready  = grant_if;
  assign ls_ready  = grant_ls;
  assign store_acc = grant_ls && ls_we;

  always_comb begin
    ram_addr = addr_q;
    if (grant_if) begin
      ram_addr = if_addr;
    end else if (grant_ls) begin
      ram_addr = ls_addr;
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_wmask = 4'b0000;
    ram_din   = 32'h0;
    if (store_acc) begin
      ram_we  = 1'b1;
      ram_din = ls_wdata;
      case (ls_size)
        2'b00:   ram_wmask = 4'b0001;
        2'b01:   ram_wmask = 4'b0011;
        default: ram_wmask = 4'b1111;
      endcase
    end
  end

  // Extraction uses the size/sign captured at accept, not the live inputs.
  always_comb begin
    load_data = ram_dout;
    case (size_q)
      2'b00:   load_data = {{24{signed_q & ram_dout[7]}}, ram_dout[7:0]};
      2'b01:   load_data = {{16{signed_q & ram_dout[15]}}, ram_dout[15:0]};
      default: load_data = ram_dout;
    endcase
  end

  // A flush in the response cycle still has to hide the already-registered pulse.
  assign if_rsp_valid = if_rsp_q && !if_flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_ls      <= 1'b1;
      addr_q       <= '0;
      size_q       <= 2'b10;
      signed_q     <= 1'b0;
      if_rsp_q     <= 1'b0;
      if_rsp_data  <= 32'h0;
      ls_rsp_valid <= 1'b0;
      ls_rsp_data  <= 32'h0;
    end else begin
      if_rsp_q     <= 1'b0;
      ls_rsp_valid <= 1'b0;

      if (grant_if) begin
        last_ls <= 1'b0;
        addr_q  <= if_addr;
      end else if (grant_ls) begin
        last_ls  <= 1'b1;
        addr_q   <= ls_addr;
        size_q   <= ls_size;
        signed_q <= ls_signed;
      end

      if (store_acc) begin
        ls_rsp_valid <= 1'b1;
        ls_rsp_data  <= 32'h0;
      end

      if (state == IF_RD && !if_flush) begin
        if_rsp_q    <= 1'b1;
        if_rsp_data <= ram_dout;
      end

      if (state == LS_RD) begin
        ls_rsp_valid <= 1'b1;
        ls_rsp_data  <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-addressed RAM, timestamp-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic with resets.
module tb_mem_arbiter;
  localparam int AW  = 16;
  localparam int MSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_valid = 1'b0;
  logic          if_ready;
  logic [AW-1:0] if_addr = '0;
  logic          if_rsp_valid;
  logic [31:0]   if_rsp_data;
  logic          if_flush = 1'b0;
  logic          ls_valid = 1'b0;
  logic          ls_ready;
  logic [AW-1:0] ls_addr = '0;
  logic          ls_we = 1'b0;
  logic [1:0]    ls_size = 2'b00;
  logic          ls_signed = 1'b0;
  logic [31:0]   ls_wdata = 32'h0;
  logic          ls_rsp_valid;
  logic [31:0]   ls_rsp_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [3:0]    ram_wmask;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout = 32'h0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_flush(if_flush),
    .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_addr(ls_addr), .ls_we(ls_we),
    .ls_size(ls_size), .ls_signed(ls_signed), .ls_wdata(ls_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wmask(ram_wmask),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(int a);
    case (a)
      'h10:    return 8'h13;
      'h11:    return 8'h05;
      'h12:    return 8'hA0;
      'h13:    return 8'h00;
      'h03:    return 8'h80;
      'h40:    return 8'h01;
      'h41:    return 8'h80;
      default: return 8'((a * 37 + 11) ^ (a >> 8));
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // RAM seen by the DUT: word read registered on the edge, byte-lane writes at addr+i.
  logic [7:0] ram_mem [MSZ];
  initial begin
    for (int i = 0; i < MSZ; i++) ram_mem[i] = init_byte(i);
    forever begin
      @(posedge clk);
      ram_dout <= {ram_mem[(int'(ram_addr) + 3) % MSZ], ram_mem[(int'(ram_addr) + 2) % MSZ],
                   ram_mem[(int'(ram_addr) + 1) % MSZ], ram_mem[int'(ram_addr)]};
      if (ram_we)
        for (int i = 0; i < 4; i++)
          if (ram_wmask[i]) ram_mem[(int'(ram_addr) + i) % MSZ] = ram_din[8*i +: 8];
    end
  end

  // Reference model: separate memory image, plus the cycle numbers at which the arbiter
  // becomes free and at which each response is due.
  logic [7:0]    mdl_mem [MSZ];
  bit            m_init = 0;
  bit            m_last_ls = 1;
  int            m_free = 0;
  int            m_if_c = -10;
  int            m_ls_c = -10;
  bit            m_if_fl = 0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0]   m_if_d = 32'h0;
  logic [31:0]   m_ls_pend = 32'h0;
  logic [31:0]   m_ls_reg = 32'h0;

  function automatic logic [31:0] mdl_word(int a);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < 4; i++) w = w + (32'(mdl_mem[(a + i) % MSZ]) << (8 * i));
    return w;
  endfunction

  function automatic logic [31:0] extract(logic [31:0] w, logic [1:0] sz, logic sg);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = w % 256;
      if (sg && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = w % 65536;
      if (sg && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  initial begin
    int c;
    bit gif, gls, e_ifv, e_lsv, e_we;
    logic [3:0]    e_mask;
    logic [AW-1:0] e_addr;
    for (int i = 0; i < MSZ; i++) mdl_mem[i] = init_byte(i);
    forever begin
      @(negedge clk);
      c = cyc;
      if (m_ls_c == c) m_ls_reg = m_ls_pend;
      gif = 0; gls = 0; e_we = 0; e_mask = 4'd0; e_addr = m_addr;
      e_ifv = (m_if_c == c) && !m_if_fl && !if_flush;
      e_lsv = (m_ls_c == c);
      if (rst_n && m_init && c >= m_free) begin
        gif = if_valid && (!ls_valid || m_last_ls);
        gls = ls_valid && !gif;
        if (gif) e_addr = if_addr;
        else if (gls) e_addr = ls_addr;
        if (gls && ls_we) begin
          e_we = 1;
          e_mask = (ls_size == 2'd0) ? 4'd1 : (ls_size == 2'd1) ? 4'd3 : 4'd15;
        end
      end
      chk("if_ready", 32'(if_ready), 32'(gif));
      chk("ls_ready", 32'(ls_ready), 32'(gls));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("ram_wmask", 32'(ram_wmask), 32'(e_mask));
      if (e_we) chk("ram_din", ram_din, ls_wdata);
      if (m_init) begin
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("if_rsp_valid", 32'(if_rsp_valid), 32'(e_ifv));
        chk("ls_rsp_valid", 32'(ls_rsp_valid), 32'(e_lsv));
        chk("ls_rsp_data", ls_rsp_data, m_ls_reg);
        if (e_ifv) chk("if_rsp_data", if_rsp_data, m_if_d);
      end
      if (!rst_n) begin
        m_init = 1; m_free = c + 1; m_last_ls = 1; m_addr = '0;
        m_if_c = -10; m_ls_c = -10; m_if_fl = 0; m_ls_reg = 32'h0;
      end else begin
        if (if_flush && m_if_c == c + 1) m_if_fl = 1;
        if (gif) begin
          m_if_c = c + 2; m_free = c + 2; m_if_fl = 0; m_last_ls = 0;
          m_if_d = mdl_word(int'(if_addr)); m_addr = if_addr;
        end else if (gls) begin
          m_last_ls = 1; m_addr = ls_addr;
          if (ls_we) begin
            for (int i = 0; i < 4; i++)
              if (e_mask[i]) mdl_mem[(int'(ls_addr) + i) % MSZ] = ls_wdata[8*i +: 8];
            m_ls_c = c + 1; m_ls_pend = 32'h0;
          end else begin
            m_ls_c = c + 2; m_free = c + 2;
            m_ls_pend = extract(mdl_word(int'(ls_addr)), ls_size, ls_signed);
          end
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string nm, input logic [AW-1:0] a, input logic [1:0] sz,
                         input logic sg, input logic [31:0] exp);
    ls_valid = 1; ls_we = 0; ls_addr = a; ls_size = sz; ls_signed = sg;
    @(negedge clk); chk({nm, "_rdy"}, 32'(ls_ready), 32'd1);
    nxt(); ls_valid = 0; ls_size = ~sz; ls_signed = ~sg;
    @(negedge clk); chk({nm, "_early"}, 32'(ls_rsp_valid), 32'd0);
    nxt();
    @(negedge clk); chk({nm, "_vld"}, 32'(ls_rsp_valid), 32'd1); chk({nm, "_data"}, ls_rsp_data, exp);
    nxt();
  endtask

  initial begin
    logic [31:0] w20;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    if_valid = 1; if_addr = 16'h0010;
    @(negedge clk); chk("fetch_ready", 32'(if_ready), 32'd1); chk("fetch_addr", 32'(ram_addr), 32'h10);
    nxt(); if_valid = 0;
    @(negedge clk); chk("fetch_t1", 32'(if_rsp_valid), 32'd0);
    nxt();
    @(negedge clk); chk("fetch_t2", 32'(if_rsp_valid), 32'd1); chk("fetch_data", if_rsp_data, 32'h00A0_0513);
    nxt();
    @(negedge clk); chk("fetch_t3", 32'(if_rsp_valid), 32'd0);
    nxt();

    do_load("lb_s", 16'h0003, 2'd0, 1'b1, 32'hFFFF_FF80);
    do_load("lb_u", 16'h0003, 2'd0, 1'b0, 32'h0000_0080);
    do_load("lh_s", 16'h0040, 2'd1, 1'b1, 32'hFFFF_8001);

    ls_valid = 1; ls_we = 1; ls_addr = 16'h0021; ls_size = 2'd1; ls_wdata = 32'h1234_ABCD;
    @(negedge clk);
    chk("st_we", 32'(ram_we), 32'd1); chk("st_mask", 32'(ram_wmask), 32'h3);
    chk("st_din", ram_din, 32'h1234_ABCD);
    nxt(); ls_valid = 0; ls_we = 0;
    @(negedge clk);
    chk("st_we_off", 32'(ram_we), 32'd0); chk("st_rsp", 32'(ls_rsp_valid), 32'd1);
    chk("st_rsp_data", ls_rsp_data, 32'h0);
    nxt();
    w20 = {init_byte('h23), 8'hAB, 8'hCD, init_byte('h20)};
    do_load("lw_after_st", 16'h0020, 2'd2, 1'b0, w20);

    if_valid = 1; if_addr = 16'h0010;
    @(negedge clk); chk("fl_ready", 32'(if_ready), 32'd1);
    nxt(); if_valid = 0; if_flush = 1;
    ls_valid = 1; ls_we = 0; ls_addr = 16'h0040; ls_size = 2'd1; ls_signed = 1;
    @(negedge clk); chk("fl_busy", 32'(ls_ready), 32'd0);
    nxt(); if_flush = 0;
    @(negedge clk); chk("fl_rsp", 32'(if_rsp_valid), 32'd0); chk("fl_ls_acc", 32'(ls_ready), 32'd1);
    nxt(); ls_valid = 0;
    nxt(); nxt();

    ls_valid = 1; ls_we = 0; ls_addr = 16'h0003; ls_size = 2'd0; ls_signed = 1;
    @(negedge clk); chk("rs_acc", 32'(ls_ready), 32'd1);
    nxt(); ls_valid = 0; rst_n = 0;
    @(negedge clk); chk("rs_rdy", 32'(ls_ready), 32'd0);
    nxt();
    @(negedge clk);
    chk("rs_lsv", 32'(ls_rsp_valid), 32'd0); chk("rs_addr", 32'(ram_addr), 32'd0);
    chk("rs_lsd", ls_rsp_data, 32'd0); chk("rs_ifd", if_rsp_data, 32'd0);
    chk("rs_we", 32'(ram_we), 32'd0); chk("rs_ifv", 32'(if_rsp_valid), 32'd0);
    nxt(); rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("rs_after", 32'(ls_rsp_valid), 32'd0);
      nxt();
    end

    if_valid = 1; if_addr = 16'h0010; ls_valid = 1; ls_we = 0; ls_addr = 16'h0040; ls_size = 2'd2;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("alt_if", 32'(if_ready), 32'((k % 4) == 0));
      chk("alt_ls", 32'(ls_ready), 32'((k % 4) == 2));
      nxt();
    end
    if_valid = 0; ls_valid = 0;
    nxt(); nxt();

    for (int k = 0; k < 4000; k++) begin
      if_valid  = ($urandom % 3) != 0;
      ls_valid  = ($urandom % 3) != 0;
      ls_we     = ($urandom % 2) != 0;
      ls_size   = 2'($urandom);
      ls_signed = 1'($urandom);
      ls_wdata  = $urandom;
      if_flush  = ($urandom % 8) == 0;
      case ($urandom % 4)
        0:       begin if_addr = 16'($urandom); ls_addr = 16'($urandom); end
        1:       begin if_addr = 16'hFFFC + 16'($urandom % 4); ls_addr = 16'hFFFC + 16'($urandom % 4); end
        default: begin if_addr = 16'($urandom % 64); ls_addr = 16'($urandom % 64); end
      endcase
      rst_n = ($urandom % 150) != 0;
      nxt();
    end
    rst_n = 1; if_valid = 0; ls_valid = 0; if_flush = 0;
    repeat (4) nxt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
